// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front-end: holds the PC, fetches 32-bit instruction
// words from a synchronous-read instruction memory, presents the decoded
// instruction fields, and computes the next PC (sequential, branch or jump)
// from the control unit's decisions at the end of EXECUTE.
//
// Each instruction takes FETCH -> WAIT -> EXECUTE (3 cycles minimum). An
// EXECUTE that sees memory_busy parks in STALL until the data memory frees.
// The PC is updated on the edge that ends EXECUTE, so during STALL and the
// following FETCH the PC already points at the next instruction.
//
// ADDR_WIDTH is intended to be at most 26, so that a jump target always
// covers the full PC.

module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  processor_enable,
    input  logic [31:0]           imem_data,
    input  logic                  branch,
    input  logic                  jump,
    input  logic                  alu_zero,
    input  logic                  memory_busy,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [5:0]            instruction_opcode,
    output logic [4:0]            instruction_rs,
    output logic [4:0]            instruction_rt,
    output logic [4:0]            instruction_rd,
    output logic [4:0]            instruction_shamt,
    output logic [5:0]            instruction_func,
    output logic [15:0]           instruction_immediate,
    output logic [25:0]           instruction_target,
    output logic                  instruction_valid
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_STALL   = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Sign-extend a 16-bit branch offset to the PC width. Bits beyond the
    // PC width are dropped, which gives the modulo-2^ADDR_WIDTH wrap the
    // branch arithmetic relies on.
    function automatic logic [ADDR_WIDTH-1:0] sext_offset(input logic [15:0] imm);
        logic [ADDR_WIDTH-1:0] res;
        res = {ADDR_WIDTH{1'b0}};
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (i < 16) begin
                res[i] = imm[i[3:0]];
            end else begin
                res[i] = imm[15];
            end
        end
        return res;
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] pc_next_s;
    logic [31:0]           ir_r;
    logic [31:0]           ir_next_s;
    logic                  valid_r;
    logic [ADDR_WIDTH-1:0] pc_seq_s;
    logic [ADDR_WIDTH-1:0] pc_branch_s;
    logic [ADDR_WIDTH-1:0] pc_jump_s;

    // Candidate next-PC values; only one is selected, and only in EXECUTE.
    always_comb begin
        pc_seq_s    = pc_r + PC_ONE;
        pc_branch_s = pc_r + PC_ONE + sext_offset(ir_r[15:0]);
        pc_jump_s   = ir_r[ADDR_WIDTH-1:0];
    end

    // Next-state logic of the fetch sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (processor_enable) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                state_next_s = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (memory_busy) begin
                    state_next_s = ST_STALL;
                end else if (processor_enable) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (memory_busy) begin
                    state_next_s = ST_STALL;
                end else if (processor_enable) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next PC: jump beats a taken branch, which beats sequential; the
    // control inputs are ignored in every state other than EXECUTE.
    always_comb begin
        pc_next_s = pc_r;
        if (state_r == ST_EXECUTE) begin
            if (jump) begin
                pc_next_s = pc_jump_s;
            end else if (branch && alu_zero) begin
                pc_next_s = pc_branch_s;
            end else begin
                pc_next_s = pc_seq_s;
            end
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Instruction register captures the memory word at the end of WAIT.
    always_comb begin
        ir_next_s = ir_r;
        if (state_r == ST_WAIT) begin
            ir_next_s = imem_data;
        end else begin
            ir_next_s = ir_r;
        end
    end

    // Sequencer state, PC, IR and the EXECUTE-valid flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            ir_r    <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            ir_r    <= ir_next_s;
            valid_r <= (state_next_s == ST_EXECUTE);
        end
    end

    // Outputs come straight from registers: the PC doubles as the memory
    // address and the fields are fixed slices of the instruction register.
    always_comb begin
        imem_address          = pc_r;
        pc                    = pc_r;
        instruction_opcode    = ir_r[31:26];
        instruction_rs        = ir_r[25:21];
        instruction_rt        = ir_r[20:16];
        instruction_rd        = ir_r[15:11];
        instruction_shamt     = ir_r[10:6];
        instruction_func      = ir_r[5:0];
        instruction_immediate = ir_r[15:0];
        instruction_target    = ir_r[25:0];
        instruction_valid     = valid_r;
    end

endmodule
